alu_issue: RTL

- Execute-stage issue register that drives the existing ALU interface (`alu_op`, `alu_a`, `alu_b`), i.e. the producer side of that ALU.
- Accepts a decoded-stage RV32I instruction with its PC and register-file read data, then decodes the ALU operation and selects the operands.
- Holds the result in a valid/ready pipeline register with stall and flush support.
- Covers the OP, OP-IMM, LUI and AUIPC major opcodes.

---
 rtl/alu_issue_if.sv | 46 ++++
 rtl/alu_issue.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/alu_issue_if.sv
// alu_issue_if: upstream instruction handshake plus the issued ALU operation
// for the execute-stage issue register. The slave modport is the issue
// register's view; master is the surrounding pipeline's view.
// Also provides the shared ALU opcode encoding when no other file has.

`ifndef ALUADD
`define ALUADD  4'd0
`define ALUSUB  4'd1
`define ALUSLL  4'd2
`define ALUSLT  4'd3
`define ALUSLTU 4'd4
`define ALUXOR  4'd5
`define ALUSRL  4'd6
`define ALUSRA  4'd7
`define ALUOR   4'd8
`define ALUAND  4'd9
`endif

interface alu_issue_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            out_valid;
    logic            out_ready;
    logic [OPW-1:0]  alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [4:0]      rd;
    logic            illegal;

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_op, alu_a, alu_b, rd, illegal
    );

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_op, alu_a, alu_b, rd, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: execute-stage issue register. Decodes OP / OP-IMM / LUI / AUIPC
// RV32I instructions into an ALU opcode and operands, held in a single
// valid/ready register with stall and flush. Unsupported encodings issue as a
// benign ADD 0,0 -> x0 with illegal set.
// Optional: define ALU_ISSUE_PERF_EN to add issued_cnt / illegal_cnt counters.

module alu_issue #(
    parameter int XLEN = 32,
    parameter int OPW  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0] issued_cnt,
    output logic [31:0] illegal_cnt,
`endif
    alu_issue_if.slave  bus
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    // funct3 to base ALU operation (ADD/SRL variants before funct7 refinement)
    function automatic logic [OPW-1:0] base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  return `ALUADD;
            3'b001:  return `ALUSLL;
            3'b010:  return `ALUSLT;
            3'b011:  return `ALUSLTU;
            3'b100:  return `ALUXOR;
            3'b101:  return `ALUSRL;
            3'b110:  return `ALUOR;
            default: return `ALUAND;
        endcase
    endfunction

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic signed [11:0] imm12;
    logic signed [31:0] immu;
    logic [XLEN-1:0]   imm_i;
    logic [XLEN-1:0]   imm_u;
    logic [XLEN-1:0]   shamt;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];
    assign imm12  = bus.instr[31:20];
    assign immu   = {bus.instr[31:12], 12'b0};
    assign imm_i  = XLEN'(imm12);
    assign imm_u  = XLEN'(immu);
    assign shamt  = XLEN'(bus.instr[24:20]);

    logic [OPW-1:0]  dec_op;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [4:0]      dec_rd;
    logic            dec_ill;

    // Decode the incoming instruction; illegal encodings collapse to ADD 0,0 -> x0
    always_comb begin
        dec_op  = `ALUADD;
        dec_a   = '0;
        dec_b   = '0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a = bus.rs1_data;
                dec_b = bus.rs2_data;
                if (funct7 == F7_BASE) begin
                    dec_op = base_op(funct3);
                end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
                    dec_op = `ALUSUB;
                end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
                    dec_op = `ALUSRA;
                end else begin
                    dec_ill = 1'b1;
                end
            end
            OPC_IMM: begin
                dec_a  = bus.rs1_data;
                dec_b  = imm_i;
                dec_op = base_op(funct3);
                if (funct3 == 3'b001) begin
                    dec_b = shamt;
                    if (funct7 != F7_BASE) dec_ill = 1'b1;
                end else if (funct3 == 3'b101) begin
                    dec_b = shamt;
                    if (funct7 == F7_ALT) dec_op = `ALUSRA;
                    else if (funct7 != F7_BASE) dec_ill = 1'b1;
                end
            end
            OPC_LUI: begin
                dec_a = '0;
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = bus.pc;
                dec_b = imm_u;
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill) begin
            dec_op = `ALUADD;
            dec_a  = '0;
            dec_b  = '0;
        end
        dec_rd = dec_ill ? 5'd0 : bus.instr[11:7];
    end

    logic            vld_p1;
    logic [OPW-1:0]  op_p1;
    logic [XLEN-1:0] a_p1;
    logic [XLEN-1:0] b_p1;
    logic [4:0]      rd_p1;
    logic            ill_p1;
    logic            accept;

    assign bus.in_ready = !flush && (!vld_p1 || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;

    // ---- stage p1: issue register (flush beats accept and drain) ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            op_p1  <= '0;
            a_p1   <= '0;
            b_p1   <= '0;
            rd_p1  <= '0;
            ill_p1 <= 1'b0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            op_p1  <= dec_op;
            a_p1   <= dec_a;
            b_p1   <= dec_b;
            rd_p1  <= dec_rd;
            ill_p1 <= dec_ill;
        end else if (bus.out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.alu_op    = op_p1;
    assign bus.alu_a     = a_p1;
    assign bus.alu_b     = b_p1;
    assign bus.rd        = rd_p1;
    assign bus.illegal   = ill_p1;

`ifdef ALU_ISSUE_PERF_EN
    // Count downstream handshakes, and those carrying an illegal entry
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issued_cnt  <= '0;
            illegal_cnt <= '0;
        end else if (vld_p1 && bus.out_ready) begin
            issued_cnt <= issued_cnt + 32'd1;
            if (ill_p1) illegal_cnt <= illegal_cnt + 32'd1;
        end
    end
`endif

endmodule
